// File: rtl/ext_pkg.sv
// Immediate extension modes and a width-generic extend() helper shared by
// the decoder and the clocked extender.
package ext_pkg;

  typedef enum logic [1:0] {
    EXT_SIGN  = 2'd0,
    EXT_ZERO  = 2'd1,
    EXT_UPPER = 2'd2,
    EXT_SHL2  = 2'd3
  } ext_mode_t;

  // Widest immediate/result the helper handles; callers truncate to their width.
  localparam int unsigned EXT_MAX_W = 64;

  function automatic logic [EXT_MAX_W-1:0] extend(
    input logic [EXT_MAX_W-1:0] imm,
    input int unsigned          in_w,
    input int unsigned          out_w,
    input ext_mode_t            mode
  );
    logic [EXT_MAX_W-1:0] in_mask;
    logic [EXT_MAX_W-1:0] out_mask;
    logic [EXT_MAX_W-1:0] zext;
    logic [EXT_MAX_W-1:0] sext;
    logic [EXT_MAX_W-1:0] res;
    logic                 sign;
    in_mask  = ~({EXT_MAX_W{1'b1}} << in_w);
    out_mask = ~({EXT_MAX_W{1'b1}} << out_w);
    zext     = imm & in_mask;
    // in_mask ^ (in_mask >> 1) isolates the immediate's MSB position
    sign     = |(zext & (in_mask ^ (in_mask >> 1)));
    sext     = sign ? (zext | ~in_mask) : zext;
    case (mode)
      EXT_SIGN:  res = sext;
      EXT_ZERO:  res = zext;
      EXT_UPPER: res = zext << (out_w - in_w);
      default:   res = sext << 2;
    endcase
    return res & out_mask;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word: rd_data shows the oldest entry
// one edge after it is written and holds its last value once empty.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    rd_ptr_next;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] head_reg;
  logic             push;
  logic             pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign count   = count_reg;
  assign rd_data = head_reg;

  always_comb begin
    rd_ptr_next = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
    count_next  = count_reg + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      // The incoming word becomes the head only when nothing older remains.
      if (count_next != '0)
        head_reg <= (push && (rd_ptr_next == wr_ptr_reg)) ? wr_data : mem[rd_ptr_next];
    end
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Clocked immediate extender: extends IN_W->OUT_W per mode, prepends a toggling
// tag bit so EX can tell repeated immediates apart, and queues results.
module imm_ext_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_imm,
  input  logic [1:0]             in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W:0]         out_data,
  output logic [$clog2(DEPTH):0] count
);

  logic             tag_reg;
  logic             push;
  logic             full;
  logic             empty;
  logic [OUT_W-1:0] ext_val;

  assign ext_val   = OUT_W'(extend(EXT_MAX_W'(in_imm), IN_W, OUT_W, ext_mode_t'(in_mode)));
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    tag_reg <= 1'b0;
    else if (push) tag_reg <= ~tag_reg;
  end

  sync_fifo #(
    .WIDTH (OUT_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_valid),
    .wr_data ({tag_reg, ext_val}),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

endmodule
